vga_capture: RTL and testbench

Pixel-stream capture block for the VGA path: the receive-side counterpart of the on-board VGA timing generator and ROM reader. It samples an 8-bit RGB stream with negative-polarity HS/VS on a pixel clock-enable, recovers the h/v position from the sync edges, and writes one W×H window of one frame into a frame RAM through a 16-bit write port. It sits between the video source and the frame RAM that the display path later reads.

---
 rtl/vga_capture.sv | 97 +++++++++
 tb/tb_vga_capture.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// vga_capture: recovers h/v position from HS/VS falls and writes one W x H window of a frame to RAM
module vga_capture #(
  parameter int H_START = 160,
  parameter int V_START = 45,
  parameter int W       = 164,
  parameter int H       = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_ce,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [7:0]  vga_rgb,
  input  logic        cap_start,
  output logic        busy,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        frame_done,
  output logic        frame_err
);
  localparam logic [10:0] H_LO = 11'(H_START);
  localparam logic [10:0] H_HI = 11'(H_START + W);
  localparam logic [10:0] V_LO = 11'(V_START);
  localparam logic [10:0] V_HI = 11'(V_START + H);
  localparam logic [15:0] LAST = 16'(W * H - 1);
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE} state_t;
  state_t      state_q;
  logic        hs_p_q, vs_p_q, busy_q, wr_en_q, frame_done_q, frame_err_q;
  logic [9:0]  h_cnt_q, v_cnt_q;
  logic [15:0] wr_addr_q;
  logic [7:0]  wr_data_q;
  logic        hs_fall, vs_fall, in_win, last;
  logic [9:0]  h_inc, v_inc, h_now, v_now, col, row;
  logic [15:0] addr;
  always_comb begin
    hs_fall = !vga_hs && hs_p_q;
    vs_fall = !vga_vs && vs_p_q;
    h_inc   = &h_cnt_q ? h_cnt_q : h_cnt_q + 10'd1;
    v_inc   = &v_cnt_q ? v_cnt_q : v_cnt_q + 10'd1;
    h_now   = hs_fall ? 10'd0 : h_inc;
    v_now   = vs_fall ? 10'd0 : hs_fall ? v_inc : v_cnt_q;
    in_win  = {1'b0, h_now} >= H_LO && {1'b0, h_now} < H_HI &&
              {1'b0, v_now} >= V_LO && {1'b0, v_now} < V_HI;
    col     = h_now - 10'(H_START);
    row     = v_now - 10'(V_START);
    addr    = 16'(row) * 16'(W) + 16'(col);
    last    = addr == LAST;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hs_p_q       <= 1'b1;
      vs_p_q       <= 1'b1;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      busy_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= state_q != IDLE || (cap_start && !busy_q);
      if (pix_ce) begin
        hs_p_q  <= vga_hs;
        vs_p_q  <= vga_vs;
        h_cnt_q <= h_now;
        v_cnt_q <= v_now;
      end
      case (state_q)
        IDLE: if (cap_start && !busy_q) state_q <= ARM;
        ARM: if (pix_ce && vs_fall) state_q <= CAPTURE;
        CAPTURE: if (pix_ce) begin
          frame_err_q <= vs_fall;
          if (in_win) begin
            wr_en_q      <= 1'b1;
            wr_addr_q    <= addr;
            wr_data_q    <= vga_rgb;
            frame_done_q <= last;
            if (last) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy       = busy_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: scoreboard bench for a small-window instance and a default-parameter instance
module tb_vga_capture;
  typedef struct {logic [15:0] a; logic [7:0] d; logic done;} ent_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, fails = 0, err_exp = 0, err_seen = 0, voff = 0;
  bit armed = 0, capturing = 0, d_fin = 0;
  ent_t sq[$], dq[$];
  logic s_rst_n, s_ce, s_hs, s_vs, s_cap, s_busy, s_wr_en, s_done, s_err;
  logic [7:0] s_rgb, s_wr_data;
  logic [15:0] s_wr_addr;
  logic d_rst_n, d_ce, d_hs, d_vs, d_cap, d_busy, d_wr_en, d_done, d_err;
  logic [7:0] d_rgb, d_wr_data;
  logic [15:0] d_wr_addr;
  vga_capture #(.H_START(4), .V_START(3), .W(5), .H(4)) u_small (
    .clk(clk), .rst_n(s_rst_n), .pix_ce(s_ce), .vga_hs(s_hs), .vga_vs(s_vs), .vga_rgb(s_rgb),
    .cap_start(s_cap), .busy(s_busy), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .frame_done(s_done), .frame_err(s_err));
  vga_capture u_def (
    .clk(clk), .rst_n(d_rst_n), .pix_ce(d_ce), .vga_hs(d_hs), .vga_vs(d_vs), .vga_rgb(d_rgb),
    .cap_start(d_cap), .busy(d_busy), .wr_en(d_wr_en), .wr_addr(d_wr_addr), .wr_data(d_wr_data),
    .frame_done(d_done), .frame_err(d_err));
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", n, act, req, $time);
    end
  endtask
  task automatic chk_quiet(input string n, input logic b, input logic e, input logic [15:0] a,
                           input logic [7:0] d, input logic dn, input logic er);
    chk({n, "_busy"}, b, 0);
    chk({n, "_wr_en"}, e, 0);
    chk({n, "_wr_addr"}, a, 0);
    chk({n, "_wr_data"}, d, 0);
    chk({n, "_frame_done"}, dn, 0);
    chk({n, "_frame_err"}, er, 0);
  endtask
  // small instance: 16-pixel lines, HS low for pixels 0-1, 12-line frames, VS low for lines 0-1
  task automatic spix(input int l, input int p, input bit vsl, input bit cp);
    ent_t e;
    int vv;
    bit acc;
    @(negedge clk);
    s_hs = p >= 2; s_vs = !vsl; s_rgb = {l[3:0], p[3:0]}; s_ce = 1; s_cap = cp;
    vv = l - voff;
    if (capturing && vv >= 3 && vv < 7 && p >= 4 && p < 9) begin
      e.a = 16'((vv - 3) * 5 + p - 4); e.d = s_rgb; e.done = e.a == 16'd19;
      sq.push_back(e);
      if (e.done) capturing = 0;
    end
    acc = cp && !armed && !capturing;
    @(negedge clk);
    s_ce = 0; s_cap = 0;
    if (acc) begin
      armed = 1;
      chk("busy_after_cap", s_busy, 1);
    end
  endtask
  task automatic sframe(input int ca, input int cb, input int gl, input int ra);
    voff = 0;
    for (int l = 0; l < 12; l++)
      for (int p = 0; p < 16; p++) begin
        if (l == 0 && p == 0 && armed) begin armed = 0; capturing = 1; end
        if (l == gl && p == 10) begin err_exp++; voff = gl; end
        spix(l, p, l < 2 || (l == gl && p >= 10 && p < 12), (l == ca || l == cb) && p == 0);
        if (l == ra && p == 6) begin
          #2 s_rst_n = 0;
          #1 chk_quiet("mid_reset", s_busy, s_wr_en, s_wr_addr, s_wr_data, s_done, s_err);
          sq.delete(); armed = 0; capturing = 0;
          #4 s_rst_n = 1;
        end
      end
  endtask
  initial begin : small_mon
    ent_t e;
    bit done_prev = 0;
    forever begin
      @(negedge clk);
      if (s_wr_en) begin
        if (sq.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_write actual_addr=%0d actual_data=%0h required=no_write", s_wr_addr, s_wr_data);
        end else begin
          e = sq.pop_front();
          chk("wr_addr", s_wr_addr, e.a);
          chk("wr_data", s_wr_data, e.d);
          chk("frame_done", s_done, e.done);
        end
      end else if (s_done) chk("done_without_write", s_done, 0);
      if (s_done) chk("busy_at_done", s_busy, 1);
      if (done_prev) chk("busy_after_done", s_busy, 0);
      done_prev = s_done;
      if (s_err) err_seen++;
    end
  end
  initial begin : def_mon
    ent_t e;
    forever begin
      @(negedge clk);
      if (d_wr_en) begin
        if (dq.size() == 0) begin
          checks++; fails++;
          $display("FAIL def_unexpected_write actual_addr=%0d required=no_write", d_wr_addr);
        end else begin
          e = dq.pop_front();
          chk("def_wr_addr", d_wr_addr, e.a);
          chk("def_wr_data", d_wr_data, e.d);
          chk("def_frame_done", d_done, e.done);
        end
      end
      if (d_err) chk("def_frame_err", d_err, 0);
    end
  end
  // default instance: 170-strobe lines reach column 160; lines 45-46 give two partial window rows
  initial begin : def_drv
    ent_t e;
    d_rst_n = 0; d_ce = 0; d_hs = 1; d_vs = 1; d_rgb = 0; d_cap = 0;
    repeat (3) @(negedge clk);
    chk_quiet("def_reset", d_busy, d_wr_en, d_wr_addr, d_wr_data, d_done, d_err);
    d_rst_n = 1;
    @(negedge clk) d_cap = 1;
    @(negedge clk) d_cap = 0;
    chk("def_busy_after_cap", d_busy, 1);
    for (int l = 0; l < 47; l++)
      for (int p = 0; p < 170; p++) begin
        @(negedge clk);
        d_hs = p >= 10; d_vs = l >= 2; d_rgb = p[7:0]; d_ce = 1;
        if (l >= 45 && p >= 160) begin
          e.a = 16'((l - 45) * 164 + p - 160); e.d = p[7:0]; e.done = 0;
          dq.push_back(e);
        end
        @(negedge clk) d_ce = 0;
      end
    repeat (3) @(negedge clk);
    chk("def_busy_still", d_busy, 1);
    d_fin = 1;
  end
  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin : main
    s_rst_n = 0; s_ce = 0; s_hs = 1; s_vs = 1; s_rgb = 0; s_cap = 0;
    repeat (3) @(negedge clk);
    chk_quiet("reset", s_busy, s_wr_en, s_wr_addr, s_wr_data, s_done, s_err);
    s_rst_n = 1;
    sframe(-1, -1, -1, -1);
    sframe(-1, -1, -1, -1);
    chk("idle_busy", s_busy, 0);
    sframe(5, -1, -1, -1);
    chk("armed_busy", s_busy, 1);
    sframe(-1, -1, -1, -1);
    chk("cap1_busy_end", s_busy, 0);
    chk("cap1_pending", sq.size(), 0);
    sframe(8, 10, -1, -1);
    sframe(4, -1, -1, -1);
    sframe(-1, -1, -1, -1);
    chk("dbl_cap_busy_end", s_busy, 0);
    chk("dbl_cap_pending", sq.size(), 0);
    sframe(9, -1, -1, -1);
    sframe(-1, -1, 5, -1);
    sframe(-1, -1, -1, -1);
    chk("frame_err_count", err_seen, err_exp);
    chk("glitch_pending", sq.size(), 0);
    sframe(9, -1, -1, -1);
    sframe(-1, -1, -1, 4);
    sframe(-1, -1, -1, -1);
    chk("post_reset_busy", s_busy, 0);
    wait (d_fin);
    chk("small_pending", sq.size(), 0);
    chk("def_pending", dq.size(), 0);
    chk("frame_err_total", err_seen, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
